// File: rtl/grf_dump_reader.sv
// -----------------------------------------------------------------------------
// grf_dump_reader
//
// Read-side sequencer for the general register file. A start pulse makes it
// walk GRF read port A from register 0 (or 1 when SKIP_ZERO=1) up to
// NUM_REGS-1. It captures each register value and streams (addr, data) beats
// to a debug/trace sink over a valid/ready interface. Each beat holds the GRF
// contents as they were at that beat's capture edge.
//
// Parameters
//   ADDR_W     GRF address width
//   DATA_W     GRF data width
//   NUM_REGS   registers to dump, 2 .. 2**ADDR_W
//   SKIP_ZERO  1: the walk starts at register 1
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   start      dump request, sampled only while idle
//   busy       high whenever a dump is in progress
//   done       one-cycle pulse after the final beat handshakes
//   rd_addr    GRF read address (registered)
//   rd_data    GRF read data (combinational read of rd_addr)
//   out_valid  beat valid
//   out_ready  sink accepts the beat
//   out_addr   register number of the beat
//   out_data   register value of the beat
//   out_last   marks the final beat of a dump
// -----------------------------------------------------------------------------
module grf_dump_reader #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter int NUM_REGS  = 32,
   parameter int SKIP_ZERO = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(SKIP_ZERO);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_SEND,
      S_DONE
   } state_t;

   state_t state;

   // NOTE: every register in this block uses non-blocking assignment, so all
   // right-hand sides see the pre-edge values. The CAPTURE step therefore
   // latches the GRF output as it was before any write on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         rd_addr   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  rd_addr <= FIRST_ADDR;
                  busy    <= 1'b1;
                  state   <= S_CAPTURE;
               end
            end

            // rd_addr has been stable for a full cycle, so rd_data is the
            // settled register value.
            S_CAPTURE: begin
               out_data  <= rd_data;
               out_addr  <= rd_addr;
               out_valid <= 1'b1;
               out_last  <= (rd_addr == LAST_ADDR);
               state     <= S_SEND;
            end

            // The beat is frozen until the sink takes it. rd_addr never
            // advances past LAST_ADDR, so it cannot wrap.
            S_SEND: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (out_last) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     rd_addr <= rd_addr + 1'b1;
                     state   <= S_CAPTURE;
                  end
               end
            end

            // A start seen in this cycle is dropped: only IDLE samples start.
            S_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               rd_addr <= '0;
               state   <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
